// File: rtl/reg_decoder_scoreboard_pkg.sv
// regdec_pkg: shared sizing constants and popcount helper for the register decoder scoreboard
package regdec_pkg;
  localparam int DEF_SEL_W = 5;
  localparam int DEF_N = 2 ** DEF_SEL_W;
  localparam int ZERO_IDX = 0;
  localparam int MAX_SEL_W = 8;
  localparam int MAX_N = 2 ** MAX_SEL_W;
  function automatic logic [MAX_SEL_W:0] popcount(input logic [MAX_N-1:0] v);
    logic [MAX_SEL_W:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) c = c + {{MAX_SEL_W{1'b0}}, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/reg_decoder_scoreboard_decoder.sv
// onehot_decoder: combinational index to one-hot, all zero when disabled
module onehot_decoder #(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      in_i,
  input  logic                  en_i,
  output logic [2**SEL_W-1:0]   out_o
);
  localparam int N = 2 ** SEL_W;
  assign out_o = {{(N-1){1'b0}}, en_i} << in_i;
endmodule

// File: rtl/reg_decoder_scoreboard.sv
// reg_decoder_scoreboard: registered one-hot write decode plus busy-bit scoreboard with issue stall.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle writeback release the stall.
module reg_decoder_scoreboard
  import regdec_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter bit ZERO_MASK = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic [SEL_W-1:0]      issue_rd_i,
  input  logic [SEL_W-1:0]      issue_rs1_i,
  input  logic [SEL_W-1:0]      issue_rs2_i,
  input  logic                  wb_valid_i,
  input  logic [SEL_W-1:0]      wb_sel_i,
  output logic                  stall_o,
  output logic [2**SEL_W-1:0]   we_onehot_o,
  output logic [2**SEL_W-1:0]   busy_o,
  output logic [SEL_W:0]        pending_cnt_o,
  output logic                  wb_err_o
);
  localparam int N = 2 ** SEL_W;
  // clears the hardwired index so it can never be tracked, enabled or flagged
  localparam logic [N-1:0] KEEP = ~({{(N-1){1'b0}}, ZERO_MASK} << ZERO_IDX);
  logic [N-1:0] rd_dec, rs1_dec, rs2_dec, wb_dec, busy_eff;
  logic [N-1:0] busy_q, busy_d, we_q, we_d;
  logic [SEL_W:0] cnt_q, cnt_d;
  logic err_q, err_d, accept;
  onehot_decoder #(.SEL_W(SEL_W)) u_rd  (.in_i(issue_rd_i),  .en_i(issue_valid_i), .out_o(rd_dec));
  onehot_decoder #(.SEL_W(SEL_W)) u_rs1 (.in_i(issue_rs1_i), .en_i(issue_valid_i), .out_o(rs1_dec));
  onehot_decoder #(.SEL_W(SEL_W)) u_rs2 (.in_i(issue_rs2_i), .en_i(issue_valid_i), .out_o(rs2_dec));
  onehot_decoder #(.SEL_W(SEL_W)) u_wb  (.in_i(wb_sel_i),    .en_i(wb_valid_i),    .out_o(wb_dec));
`ifdef SCOREBOARD_BYPASS_EN
  assign busy_eff = busy_q & ~wb_dec;
`else
  assign busy_eff = busy_q;
`endif
  assign stall_o = |(busy_eff & KEEP & (rs1_dec | rs2_dec | rd_dec));
  assign accept  = issue_valid_i & ~stall_o;
  always_comb begin
    busy_d = (busy_q & ~wb_dec) | (rd_dec & KEEP & {N{accept}});
    we_d   = wb_dec & KEEP;
    err_d  = err_q | (|(wb_dec & KEEP & ~busy_q));
    cnt_d  = (SEL_W+1)'(popcount(MAX_N'(busy_d)));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      we_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  assign we_onehot_o   = we_q;
  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;
  assign wb_err_o      = err_q;
endmodule

// File: tb/tb_reg_decoder_scoreboard.sv
// tb_reg_decoder_scoreboard: randomized and directed checks against an array-based scoreboard model
module tb_reg_decoder_scoreboard;
  localparam int SW = 5;
  localparam int NR = 32;
  localparam bit ZM = 1'b1;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic issue_valid_i = 1'b0, wb_valid_i = 1'b0;
  logic [SW-1:0] issue_rd_i = '0, issue_rs1_i = '0, issue_rs2_i = '0, wb_sel_i = '0;
  logic stall_o, wb_err_o;
  logic [NR-1:0] we_onehot_o, busy_o;
  logic [SW:0] pending_cnt_o;
  logic s_iv = 1'b0, s_wv = 1'b0;
  logic [2:0] s_rd = '0, s_rs1 = 3'd1, s_rs2 = 3'd2, s_ws = '0;
  logic s_stall, s_err;
  logic [7:0] s_we, s_busy;
  logic [3:0] s_cnt;
  int checks = 0;
  int errors = 0;
  bit m_busy [NR];
  bit m_err;

  always #5 clk_i = ~clk_i;

  reg_decoder_scoreboard #(.SEL_W(SW), .ZERO_MASK(ZM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .wb_valid_i(wb_valid_i), .wb_sel_i(wb_sel_i),
    .stall_o(stall_o), .we_onehot_o(we_onehot_o), .busy_o(busy_o), .pending_cnt_o(pending_cnt_o),
    .wb_err_o(wb_err_o));

  reg_decoder_scoreboard #(.SEL_W(3), .ZERO_MASK(1'b0)) dut_small (
    .clk_i(clk_i), .rst_ni(rst_ni), .issue_valid_i(s_iv), .issue_rd_i(s_rd),
    .issue_rs1_i(s_rs1), .issue_rs2_i(s_rs2), .wb_valid_i(s_wv), .wb_sel_i(s_ws),
    .stall_o(s_stall), .we_onehot_o(s_we), .busy_o(s_busy), .pending_cnt_o(s_cnt),
    .wb_err_o(s_err));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_beff(input int i, input bit wv, input int ws);
    if (ZM && i == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (wv && ws == i) return 1'b0;
`endif
    return m_busy[i];
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_err = 1'b0;
  endtask

  // entered just after a rising edge; leaves just after the next one
  task automatic step(input bit iv, input int rd, input int rs1, input int rs2, input bit wv, input int ws);
    bit exp_stall, acc;
    logic [NR-1:0] exp_we;
    issue_valid_i = iv; issue_rd_i = SW'(rd); issue_rs1_i = SW'(rs1); issue_rs2_i = SW'(rs2);
    wb_valid_i = wv; wb_sel_i = SW'(ws);
    #1;
    exp_stall = iv && (m_beff(rs1, wv, ws) || m_beff(rs2, wv, ws) || m_beff(rd, wv, ws));
    chk("stall", stall_o, exp_stall);
    acc = iv && !exp_stall;
    exp_we = (wv && !(ZM && ws == 0)) ? (NR'(1) << ws) : '0;
    @(posedge clk_i);
    if (wv && !(ZM && ws == 0) && !m_busy[ws]) m_err = 1'b1;
    if (wv) m_busy[ws] = 1'b0;
    if (acc && !(ZM && rd == 0)) m_busy[rd] = 1'b1;
    #1;
    chk("busy", busy_o, m_vec());
    chk("we", we_onehot_o, exp_we);
    chk("cnt", pending_cnt_o, m_cnt());
    chk("err", wb_err_o, m_err);
  endtask

  task automatic sstep(input bit iv, input int rd, input bit wv, input int ws,
                       input logic [7:0] eb, input logic [7:0] ew, input int ec, input bit ee);
    s_iv = iv; s_rd = 3'(rd); s_wv = wv; s_ws = 3'(ws);
    #1;
    chk("s_stall", s_stall, 1'b0);
    @(posedge clk_i);
    #1;
    chk("s_busy", s_busy, eb);
    chk("s_we", s_we, ew);
    chk("s_cnt", s_cnt, ec);
    chk("s_err", s_err, ee);
  endtask

  task automatic mid_reset();
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_busy", busy_o, '0);
    chk("rst_we", we_onehot_o, '0);
    chk("rst_cnt", pending_cnt_o, '0);
    chk("rst_err", wb_err_o, '0);
    chk("rst_stall", stall_o, 1'b0);
    m_clear();
    issue_valid_i = 1'b0; wb_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick();
    return ($urandom % 4 == 0) ? int'($urandom_range(0, NR-1)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    m_clear();
    #12;
    chk("reset_busy", busy_o, '0);
    chk("reset_cnt", pending_cnt_o, '0);
    chk("reset_err", wb_err_o, '0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    sstep(1, 7, 0, 0, 8'h80, 8'h00, 1, 0);
    sstep(1, 0, 0, 0, 8'h81, 8'h00, 2, 0);
    s_iv = 1'b0;
    sstep(0, 0, 1, 0, 8'h80, 8'h01, 1, 0);
    sstep(0, 0, 1, 3, 8'h80, 8'h08, 1, 1);
    s_wv = 1'b0;
    step(1, 3, 1, 2, 0, 0);
    chk("tp_busy3", busy_o, 32'h8);
    step(1, 4, 3, 0, 0, 0);
    step(1, 4, 3, 0, 1, 3);
    chk("tp_we3", we_onehot_o, 32'h8);
    step(1, 0, 0, 0, 1, 0);
    chk("tp_zero_we", we_onehot_o, '0);
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 0, 0, 1, 7);
    chk("tp_we7", we_onehot_o, 32'h80);
    step(0, 0, 0, 0, 1, 9);
    chk("tp_err9", wb_err_o, 1'b1);
    for (int i = 1; i < NR; i++) step(1, i, 0, 0, 0, 0);
    chk("fill_cnt", pending_cnt_o, 31);
    issue_valid_i = 1'b1; issue_rs1_i = 5'd3;
    mid_reset();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), pick(), pick(), pick(), 1'($urandom_range(0, 1)), pick());
      if (n == 300) mid_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
